shared_bus_arbiter: RTL and testbench

- Sits directly downstream of the per-core shared-bus ports (shared_addr/wren/rden/write_val, shared_ready, shared_read_val).
- Arbitrates NUM_CORES requesters round-robin onto one shared memory/device port, with one outstanding transaction at a time.
- Drives each core's ready/stall handshake and returns read data one cycle after ready, as the core pipeline expects.

---
 rtl/shared_bus_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
//   Round-robin arbiter that merges NUM_CORES per-core shared-bus ports onto a
//   single downstream memory/device port, one outstanding transaction at a time.
//   A transaction walks IDLE -> ACCESS -> COMPLETE. The granted core sees a
//   one-cycle core_ready pulse in COMPLETE. Read data is broadcast on
//   core_read_val and stays stable from the ready cycle until the next read
//   capture.
//
//   Optional feature (macro SHARED_BUS_TIMEOUT_EN): an ACCESS that waits
//   TIMEOUT_CYCLES cycles without mem_ack is abandoned. The core is released
//   with 16'hDEAD as read data, and the sticky bus_error flag is set.
//   Without the macro, ACCESS waits indefinitely and bus_error is tied to 0.
//
// Ports
//   clk            clock, all state on posedge
//   reset          asynchronous reset, active-low
//   core_addr      per-core address, core i at [16*i+15:16*i]
//   core_wren      per-core write request
//   core_rden      per-core read request (a write wins if both are set)
//   core_write_val per-core write data, core i at [16*i+15:16*i]
//   core_ready     per-core completion pulse (COMPLETE state only)
//   core_read_val  read data broadcast to all cores
//   mem_addr       downstream address
//   mem_wren       downstream write strobe
//   mem_rden       downstream read strobe
//   mem_write_val  downstream write data
//   mem_ack        downstream completion, may coincide with the strobe
//   mem_read_val   downstream read data, valid with mem_ack
//   bus_error      sticky timeout flag
module shared_bus_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [16*NUM_CORES-1:0] core_addr,
    input  logic [NUM_CORES-1:0]    core_wren,
    input  logic [NUM_CORES-1:0]    core_rden,
    input  logic [16*NUM_CORES-1:0] core_write_val,
    output logic [NUM_CORES-1:0]    core_ready,
    output logic [15:0]             core_read_val,
    output logic [15:0]             mem_addr,
    output logic                    mem_wren,
    output logic                    mem_rden,
    output logic [15:0]             mem_write_val,
    input  logic                    mem_ack,
    input  logic [15:0]             mem_read_val,
    output logic                    bus_error
);

    localparam int GW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    // Returns {found, index}: first requester searching upward from last+1, with wrap.
    function automatic logic [GW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [GW-1:0]        last);
        logic [GW:0]   cand;
        logic          found;
        logic [GW-1:0] idx;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = {1'b0, last} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_CORES)) begin
                cand = cand - (GW+1)'(NUM_CORES);
            end else begin
                cand = cand;
            end
            if (!found && req[cand[GW-1:0]]) begin
                found = 1'b1;
                idx   = cand[GW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // One-hot decode of a core index.
    function automatic logic [NUM_CORES-1:0] onehot(input logic [GW-1:0] idx);
        logic [NUM_CORES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [GW-1:0]        grant_r;
    logic [GW-1:0]        last_grant_r;
    logic [NUM_CORES-1:0] req_s;
    logic [GW:0]          pick_s;
    logic                 pick_valid_s;
    logic [GW-1:0]        pick_idx_s;
    logic [15:0]          addr_r;
    logic [15:0]          wdata_r;
    logic [15:0]          rdata_r;
    logic                 wren_r;
    logic                 rden_r;
    logic [NUM_CORES-1:0] ready_r;
    logic                 timeout_s;

    assign req_s        = core_wren | core_rden;
    assign pick_s       = rr_pick(req_s, last_grant_r);
    assign pick_valid_s = pick_s[GW];
    assign pick_idx_s   = pick_s[GW-1:0];

    assign core_ready    = ready_r;
    assign core_read_val = rdata_r;
    assign mem_addr      = addr_r;
    assign mem_write_val = wdata_r;
    assign mem_wren      = wren_r;
    assign mem_rden      = rden_r;

`ifdef SHARED_BUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] to_cnt_r;
    logic          bus_error_r;

    // The abandon decision fires on the ACCESS cycle where the count would reach the limit.
    assign timeout_s = (state_r == ST_ACCESS) && !mem_ack &&
                       ((to_cnt_r + TW'(1)) == TW'(TIMEOUT_CYCLES));
    assign bus_error = bus_error_r;

    // Ack-wait counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_r    <= '0;
            bus_error_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && pick_valid_s) begin
                to_cnt_r <= '0;
            end else if ((state_r == ST_ACCESS) && !mem_ack) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (timeout_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;

    assign timeout_s = 1'b0;
    assign bus_error = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_s) begin
                    state_next_s = ST_COMPLETE;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            // The completing core still drives its request here, so never grant.
            ST_COMPLETE: state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // State, captured request, downstream strobes, ready pulse and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_CORES - 1);
            addr_r       <= 16'h0000;
            wdata_r      <= 16'h0000;
            rdata_r      <= 16'h0000;
            wren_r       <= 1'b0;
            rden_r       <= 1'b0;
            ready_r      <= '0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= '0;
                    if (pick_valid_s) begin
                        grant_r      <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        addr_r       <= core_addr[{pick_idx_s, 4'b0000} +: 16];
                        wdata_r      <= core_write_val[{pick_idx_s, 4'b0000} +: 16];
                        wren_r       <= core_wren[pick_idx_s];
                        rden_r       <= core_rden[pick_idx_s] & ~core_wren[pick_idx_s];
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (rden_r) begin
                            rdata_r <= mem_read_val;
                        end
                        wren_r  <= 1'b0;
                        rden_r  <= 1'b0;
                        ready_r <= onehot(grant_r);
                    end else if (timeout_s) begin
                        if (rden_r) begin
                            rdata_r <= 16'hDEAD;
                        end
                        wren_r  <= 1'b0;
                        rden_r  <= 1'b0;
                        ready_r <= onehot(grant_r);
                    end
                end
                ST_COMPLETE: begin
                    ready_r <= '0;
                    wren_r  <= 1'b0;
                    rden_r  <= 1'b0;
                end
                default: begin
                    ready_r <= '0;
                    wren_r  <= 1'b0;
                    rden_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge. The bench models the memory side by
// raising mem_ack mid-cycle. Expected grants and read data are queued when
// stimulus is driven and popped when the DUT responds.
module tb_shared_bus_arbiter;
    localparam int N = 4;
`ifdef SHARED_BUS_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [16*N-1:0] core_addr;
    logic [N-1:0]    core_wren;
    logic [N-1:0]    core_rden;
    logic [16*N-1:0] core_write_val;
    logic [N-1:0]    core_ready;
    logic [15:0]     core_read_val;
    logic [15:0]     mem_addr;
    logic            mem_wren;
    logic            mem_rden;
    logic [15:0]     mem_write_val;
    logic            mem_ack;
    logic [15:0]     mem_read_val;
    logic            bus_error;

    txn_t        exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] last_rd = 16'h0000;
    int          total = 0;
    int          bad = 0;

    shared_bus_arbiter #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_wren(core_wren), .core_rden(core_rden),
        .core_write_val(core_write_val), .core_ready(core_ready),
        .core_read_val(core_read_val), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_write_val(mem_write_val), .mem_ack(mem_ack),
        .mem_read_val(mem_read_val), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input int c, input logic we, input logic re,
                             input logic [15:0] a, input logic [15:0] d);
        core_wren[c]                = we;
        core_rden[c]                = re;
        core_addr[16*c +: 16]       = a;
        core_write_val[16*c +: 16]  = d;
    endtask

    task automatic clear_all();
        core_wren      = '0;
        core_rden      = '0;
        core_addr      = '0;
        core_write_val = '0;
        mem_ack        = 1'b0;
        mem_read_val   = 16'h0000;
    endtask

    task automatic push_txn(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.core = c; t.we = we; t.addr = a; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        total++;
        if ({core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error} !== 55'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        txn_t t;
        int   done = 0;
        int   last_rdy = -1;
        for (int c = 0; c < N; c++) drive_req(c, 1'b1, 1'b0, 16'(16'h1000 + c), 16'(16'hA000 + c));
        for (int c = 0; c < N; c++) push_txn(c, 1'b1, 16'(16'h1000 + c), 16'(16'hA000 + c));
        push_txn(0, 1'b1, 16'h1000, 16'hA000);
        for (int cyc = 0; cyc < 60 && done < 5; cyc++) begin
            @(negedge clk);
            mem_ack = mem_wren | mem_rden;
            if ((mem_wren | mem_rden) && exp_q.size() > 0) begin
                total++;
                if ({mem_wren, mem_addr, mem_write_val} !== {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata}) begin
                    bad++;
                    $display("FAIL rr_grant got=%h/%h required=%h/%h", mem_addr, mem_write_val,
                             exp_q[0].addr, exp_q[0].wdata);
                end
            end
            if (core_ready != '0) begin
                t = exp_q.pop_front();
                total++;
                if (core_ready !== (4'b0001 << t.core)) begin
                    bad++;
                    $display("FAIL rr_ready got=%b required=%b", core_ready, 4'b0001 << t.core);
                end
                if (last_rdy >= 0) begin
                    total++;
                    if (cyc - last_rdy !== 3) begin
                        bad++;
                        $display("FAIL rr_spacing got=%0d required=3", cyc - last_rdy);
                    end
                end
                last_rdy = cyc;
                done++;
                if (done == 5) clear_all();
            end
        end
        total++;
        if (done != 5) begin
            bad++;
            $display("FAIL rr_budget got=%0d completions required=5", done);
            clear_all();
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        txn_t t;
        drive_req(2, 1'b0, 1'b1, 16'h4010, 16'h0000);
        push_txn(2, 1'b0, 16'h4010, 16'h0000);
        @(negedge clk);
        t = exp_q.pop_front();
        total++;
        if ({mem_rden, mem_wren, mem_addr} !== {1'b1, 1'b0, t.addr}) begin
            bad++;
            $display("FAIL read_strobe got=%b%b/%h required=10/%h", mem_rden, mem_wren, mem_addr, t.addr);
        end
        mem_ack = 1'b1;
        mem_read_val = 16'h1234;
        rd_q.push_back(16'h1234);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_read_val = 16'h0000;
        total++;
        if ({core_ready, mem_rden} !== {4'b0100, 1'b0}) begin
            bad++;
            $display("FAIL read_ready got=%b/%b required=0100/0", core_ready, mem_rden);
        end
        drive_req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        last_rd = rd_q.pop_front();
        total++;
        if ({core_read_val, core_ready} !== {last_rd, 4'b0000}) begin
            bad++;
            $display("FAIL read_data got=%h/%b required=%h/0000", core_read_val, core_ready, last_rd);
        end
        repeat (2) @(negedge clk);
        total++;
        if (core_read_val !== last_rd) begin
            bad++;
            $display("FAIL read_hold got=%h required=%h", core_read_val, last_rd);
        end
    endtask

    task automatic test_write_delay();
        txn_t t;
        drive_req(0, 1'b1, 1'b0, 16'h8000, 16'hBEEF);
        push_txn(0, 1'b1, 16'h8000, 16'hBEEF);
        t = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({mem_wren, mem_rden, mem_addr, mem_write_val, core_ready} !== {2'b10, t.addr, t.wdata, 4'b0000}) begin
                bad++;
                $display("FAIL write_hold_%0d got=%b%b/%h/%h/%b required=10/%h/%h/0000", k,
                         mem_wren, mem_rden, mem_addr, mem_write_val, core_ready, t.addr, t.wdata);
            end
            if (k == 3) mem_ack = 1'b1;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if ({core_ready, mem_wren, core_read_val} !== {4'b0001, 1'b0, last_rd}) begin
            bad++;
            $display("FAIL write_ready got=%b/%b/%h required=0001/0/%h", core_ready, mem_wren, core_read_val, last_rd);
        end
        drive_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        total++;
        if ({core_ready, mem_wren, mem_rden} !== 6'd0) begin
            bad++;
            $display("FAIL write_idle got=%b/%b/%b required=0", core_ready, mem_wren, mem_rden);
        end
    endtask

    task automatic test_wren_rden();
        drive_req(1, 1'b1, 1'b1, 16'h2222, 16'h5A5A);
        @(negedge clk);
        total++;
        if ({mem_wren, mem_rden, mem_addr, mem_write_val} !== {2'b10, 16'h2222, 16'h5A5A}) begin
            bad++;
            $display("FAIL both_strobe got=%b%b/%h/%h required=10/2222/5a5a", mem_wren, mem_rden, mem_addr, mem_write_val);
        end
        mem_ack = 1'b1;
        mem_read_val = 16'h9999;
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if ({core_ready, core_read_val} !== {4'b0010, last_rd}) begin
            bad++;
            $display("FAIL both_ready got=%b/%h required=0010/%h", core_ready, core_read_val, last_rd);
        end
        clear_all();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_req(1, 1'b0, 1'b1, 16'h7777, 16'h0000);
        @(negedge clk);
        total++;
        if ({mem_rden, mem_addr} !== {1'b1, 16'h7777}) begin
            bad++;
            $display("FAIL mid_strobe got=%b/%h required=1/7777", mem_rden, mem_addr);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error} !== 55'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h required=0",
                     {core_ready, core_read_val, mem_addr, mem_wren, mem_rden, mem_write_val, bus_error});
        end
        last_rd = 16'h0000;
        clear_all();
        @(negedge clk);
        reset = 1'b1;
        drive_req(0, 1'b1, 1'b0, 16'h0A00, 16'h1111);
        drive_req(2, 1'b1, 1'b0, 16'h0C00, 16'h2222);
        @(negedge clk);
        total++;
        if ({mem_wren, mem_addr, core_ready} !== {1'b1, 16'h0A00, 4'b0000}) begin
            bad++;
            $display("FAIL restart_grant got=%b/%h/%b required=1/0a00/0000", mem_wren, mem_addr, core_ready);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++;
        if (core_ready !== 4'b0001) begin
            bad++;
            $display("FAIL restart_ready got=%b required=0001", core_ready);
        end
        clear_all();
        @(negedge clk);
    endtask

`ifdef SHARED_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int   strobes = 0;
        logic got = 1'b0;
        logic [15:0] exp_rd;
        drive_req(2, 1'b0, 1'b1, 16'h0300, 16'h0000);
        rd_q.push_back(16'hDEAD);
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clk);
            if (mem_rden) strobes++;
            if (core_ready != '0) begin
                got = 1'b1;
                total++;
                if (core_ready !== 4'b0100) begin
                    bad++;
                    $display("FAIL timeout_ready got=%b required=0100", core_ready);
                end
                drive_req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        end
        total++;
        if (strobes !== TO) begin
            bad++;
            $display("FAIL timeout_len got=%0d required=%0d", strobes, TO);
        end
        @(negedge clk);
        exp_rd = rd_q.pop_front();
        total++;
        if ({core_read_val, bus_error} !== {exp_rd, 1'b1}) begin
            bad++;
            $display("FAIL timeout_data got=%h/%b required=%h/1", core_read_val, bus_error, exp_rd);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus_error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b required=1", bus_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_delay();
        test_wren_rden();
        test_reset_mid();
`ifdef SHARED_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
